pkt_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one packetizer input between NUM_PORTS Avalon-ST-style 64-bit packet sources (for example, several feed channels).
- Grants one port at a time and holds the grant for a whole packet, from SOP to EOP.
- Forwards the granted port's beats unmodified to the packetizer's data_in/start_packet/end_packet/empty/EN inputs, and returns backpressure from the packetizer's ready.

---
 rtl/pkt_stream_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_pkt_stream_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_stream_arbiter.sv
// Round-robin packet arbiter: one of NUM_PORTS streams owns the output from SOP through EOP.
// Define PKT_WATCHDOG_EN to truncate packets longer than MAX_PKT_BEATS and flush their tail.
module pkt_stream_arbiter #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned EMPTY_WIDTH   = 3,
  parameter int unsigned MAX_PKT_BEATS = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS-1:0]             in_sop,
  input  logic [NUM_PORTS-1:0]             in_eop,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EMPTY_WIDTH-1:0]           out_empty,
  input  logic                             out_ready,
`ifdef PKT_WATCHDOG_EN
  output logic                             wd_err,
`endif
  output logic [1:0]                       grant_id,
  output logic                             busy,
  output logic [31:0]                      pkt_count,
  output logic [15:0]                      drop_count
);

  if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_num_ports
    $error("pkt_stream_arbiter: NUM_PORTS must be in 2..4");
  end
  if (MAX_PKT_BEATS < 2) begin : g_bad_max_beats
    $error("pkt_stream_arbiter: MAX_PKT_BEATS must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPass
`ifdef PKT_WATCHDOG_EN
    , StFlush
`endif
  } state_e;

  state_e state_q;
  logic [1:0] ptr_q;

  // Granted-port view of the inputs
  logic                   g_valid;
  logic                   g_sop;
  logic                   g_eop;
  logic [DATA_WIDTH-1:0]  g_data;
  logic [EMPTY_WIDTH-1:0] g_empty;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] orphan;
  logic                 win_found;
  logic [1:0]           win_idx;
  logic [1:0]           ptr_next;
  logic                 xfer;
  logic [2:0]           drop_add;
  logic [16:0]          drop_sum;

`ifdef PKT_WATCHDOG_EN
  localparam int unsigned BeatW = $clog2(MAX_PKT_BEATS) + 1;
  logic [BeatW-1:0] beat_q;
  logic             wd_last;
`endif

  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    g_empty = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == 2'(i)) begin
        g_valid = in_valid[i];
        g_sop   = in_sop[i];
        g_eop   = in_eop[i];
        g_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_empty = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
      end
    end
  end

  // Two passes give "first requester at or after the pointer, wrapping".
  always_comb begin
    req       = in_valid & in_sop;
    orphan    = in_valid & ~in_sop;
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && req[i] && (2'(i) >= ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
  end

  assign ptr_next = (grant_id == 2'(NUM_PORTS - 1)) ? 2'd0 : grant_id + 2'd1;
  assign xfer     = (state_q == StPass) && g_valid && out_ready;

`ifdef PKT_WATCHDOG_EN
  assign wd_last = (beat_q == BeatW'(MAX_PKT_BEATS - 1)) && !g_eop;
`endif

  // Orphan beats are only dropped (and counted) while idle; saturating add.
  always_comb begin
    drop_add = 3'd0;
    if (state_q == StIdle) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        drop_add = drop_add + {2'b00, orphan[i]};
      end
    end
    drop_sum = {1'b0, drop_count} + {14'd0, drop_add};
  end

  always_comb begin
    in_ready = '0;
    unique case (state_q)
      StIdle: in_ready = orphan;
      StPass: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_id == 2'(i)) in_ready[i] = out_ready;
        end
      end
`ifdef PKT_WATCHDOG_EN
      StFlush: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_id == 2'(i)) in_ready[i] = 1'b1;
        end
      end
`endif
      default: in_ready = '0;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    out_empty = '0;
    if (state_q == StPass) begin
      out_valid = g_valid;
      out_sop   = g_sop;
      out_data  = g_data;
`ifdef PKT_WATCHDOG_EN
      out_eop   = g_eop | wd_last;
      out_empty = wd_last ? '0 : g_empty;
`else
      out_eop   = g_eop;
      out_empty = g_empty;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      grant_id   <= 2'd0;
      busy       <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
`ifdef PKT_WATCHDOG_EN
      beat_q     <= '0;
      wd_err     <= 1'b0;
`endif
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_id <= win_idx;
            busy     <= 1'b1;
            state_q  <= StPass;
`ifdef PKT_WATCHDOG_EN
            beat_q   <= '0;
`endif
          end
        end
        StPass: begin
          if (xfer) begin
`ifdef PKT_WATCHDOG_EN
            beat_q <= beat_q + 1'b1;
`endif
            if (g_eop) begin
              pkt_count <= pkt_count + 32'd1;
              ptr_q     <= ptr_next;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end
`ifdef PKT_WATCHDOG_EN
            else if (wd_last) begin
              // Truncated packet is closed downstream; the tail is absorbed in StFlush.
              pkt_count <= pkt_count + 32'd1;
              wd_err    <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StFlush;
            end
`endif
          end
        end
`ifdef PKT_WATCHDOG_EN
        StFlush: begin
          if (g_valid && g_eop) begin
            ptr_q   <= ptr_next;
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// Scoreboard bench for pkt_stream_arbiter; covers the watchdog when PKT_WATCHDOG_EN is defined.
module tb_pkt_stream_arbiter;
  localparam int NP = 2;
  localparam int DW = 64;
  localparam int EW = 3;
`ifdef PKT_WATCHDOG_EN
  localparam int MaxBeats = 4;
`else
  localparam int MaxBeats = 256;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]  in_valid, in_sop, in_eop, in_ready;
  logic [NP*EW-1:0] in_empty;
  logic [DW-1:0]  out_data;
  logic           out_valid, out_sop, out_eop, out_ready;
  logic [EW-1:0]  out_empty;
  logic [1:0]     grant_id;
  logic           busy;
  logic [31:0]    pkt_count;
  logic [15:0]    drop_count;
`ifdef PKT_WATCHDOG_EN
  logic           wd_err;
`endif

  pkt_stream_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .MAX_PKT_BEATS(MaxBeats)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready),
`ifdef PKT_WATCHDOG_EN
    .wd_err(wd_err),
`endif
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [1:0]  port;
  } beat_t;

  beat_t src_q[NP][$];
  beat_t exp_q[$];
  int    grant_log[$];
  int    gap_log[$];
  int    xfer_cyc_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_eop_cyc = 0;
  int    xfer_cnt = 0;
  bit    tog_en = 1'b0;
  logic  tog_val = 1'b1;

  // Snapshot of the last sampled cycle
  logic [NP-1:0] s_in_ready;
  logic          s_out_ready, s_out_valid, s_busy;
  logic [DW-1:0] s_out_data;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic make_pkt(input int p, input int n, input logic [2:0] emp, input bit to_exp);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = {$urandom, $urandom};
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.empty = (i == n - 1) ? emp : 3'd0;
      b.port  = 2'(p);
      src_q[p].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    xfer_cyc_q.delete();
    xfer_cnt = 0;
  endtask

  // One clock: present source heads, sample at negedge, score output beats, retire accepted beats.
  task automatic step();
    beat_t b;
    logic [NP-1:0] acc;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        b = src_q[p][0];
        in_valid[p] = 1'b1;
        in_sop[p]   = b.sop;
        in_eop[p]   = b.eop;
        in_data[p*DW +: DW] = b.data;
        in_empty[p*EW +: EW] = b.empty;
      end else begin
        in_valid[p] = 1'b0;
        in_sop[p]   = 1'b0;
        in_eop[p]   = 1'b0;
      end
    end
    if (tog_en) begin
      out_ready = tog_val;
      tog_val   = ~tog_val;
    end else begin
      out_ready = 1'b1;
    end
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_ready = out_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy;
    acc = in_valid & in_ready;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_beat got data=%h sop=%b eop=%b empty=%0d grant=%0d, none expected",
                 out_data, out_sop, out_eop, out_empty, grant_id);
      end else begin
        b = exp_q.pop_front();
        if ({out_data, out_sop, out_eop, out_empty, grant_id} !==
            {b.data, b.sop, b.eop, b.empty, b.port}) begin
          failures++;
          $display("FAIL sb_beat got data=%h sop=%b eop=%b empty=%0d grant=%0d exp data=%h sop=%b eop=%b empty=%0d grant=%0d",
                   out_data, out_sop, out_eop, out_empty, grant_id,
                   b.data, b.sop, b.eop, b.empty, b.port);
        end
      end
      if (out_sop) begin
        grant_log.push_back(int'(grant_id));
        gap_log.push_back(cyc - last_eop_cyc);
      end
      if (out_eop) last_eop_cyc = cyc;
      xfer_cyc_q.push_back(cyc);
      xfer_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      for (int p = 0; p < NP; p++) if (acc[p]) void'(src_q[p].pop_front());
    end
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k = 0;
    while (xfer_cnt < n && k < budget) begin
      step();
      k++;
    end
    ok = (xfer_cnt >= n);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    in_valid = '0;
    in_sop = '0;
    in_eop = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_sop, out_eop} !== 2'b00) begin failures++; $display("FAIL rst_sop_eop got %b exp 00", {out_sop, out_eop}); end
    checks++; if (out_data !== '0 || out_empty !== '0) begin failures++; $display("FAIL rst_data got %h/%0d exp 0/0", out_data, out_empty); end
    checks++; if (in_ready !== '0) begin failures++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin failures++; $display("FAIL rst_busy_grant got %b/%0d exp 0/0", busy, grant_id); end
    checks++; if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin failures++; $display("FAIL rst_counters got %0d/%0d exp 0/0", pkt_count, drop_count); end
`ifdef PKT_WATCHDOG_EN
    checks++; if (wd_err !== 1'b0) begin failures++; $display("FAIL rst_wd_err got %b exp 0", wd_err); end
`endif
  endtask

  task automatic test_single_port();
    bit ok;
    int start;
    apply_reset();
    make_pkt(0, 6, 3'd3, 1'b1);
    start = cyc;
    run_until(6, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got %0d beats exp 6", xfer_cnt); end
    checks++; if (xfer_cyc_q.size() != 6 || xfer_cyc_q[0] != start + 1) begin failures++; $display("FAIL single_latency got first=%0d exp %0d", xfer_cyc_q.size() > 0 ? xfer_cyc_q[0] - start : -1, 1); end
    checks++; if (xfer_cyc_q.size() != 6 || xfer_cyc_q[5] != start + 6) begin failures++; $display("FAIL single_consecutive got last=%0d exp %0d", xfer_cyc_q.size() == 6 ? xfer_cyc_q[5] - start : -1, 6); end
    checks++; if (pkt_count !== 32'd1) begin failures++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL single_grant got %0d exp 0", grant_id); end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    make_pkt(0, 2, 3'd1, 1'b1);
    make_pkt(1, 2, 3'd2, 1'b1);
    make_pkt(0, 2, 3'd4, 1'b1);
    make_pkt(1, 2, 3'd7, 1'b1);
    run_until(8, 80, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got %0d beats exp 8", xfer_cnt); end
    checks++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
      failures++;
      $display("FAIL rr_order got %p exp 0,1,0,1", grant_log);
    end
    checks++;
    if (gap_log.size() != 4 || gap_log[1] != 2 || gap_log[2] != 2 || gap_log[3] != 2) begin
      failures++;
      $display("FAIL rr_idle_gap got %p exp 2 cycles EOP->SOP", gap_log);
    end
    checks++; if (pkt_count !== 32'd4) begin failures++; $display("FAIL rr_pkt_count got %0d exp 4", pkt_count); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic prev_v = 1'b0, prev_r = 1'b1;
    logic [DW-1:0] prev_d = '0;
    apply_reset();
    make_pkt(0, 4, 3'd5, 1'b1);
    tog_en  = 1'b1;
    tog_val = 1'b1;
    while (xfer_cnt < 4 && k < 40) begin
      step();
      k++;
      if (s_busy) begin
        checks++;
        if (s_in_ready !== {1'b0, s_out_ready}) begin
          failures++;
          $display("FAIL bp_in_ready got %b exp %b", s_in_ready, {1'b0, s_out_ready});
        end
        if (prev_v && !prev_r && s_out_valid) begin
          checks++;
          if (s_out_data !== prev_d) begin failures++; $display("FAIL bp_stable got %h exp %h", s_out_data, prev_d); end
        end
      end
      prev_v = s_out_valid;
      prev_r = s_out_ready;
      prev_d = s_out_data;
    end
    tog_en = 1'b0;
    checks++; if (xfer_cnt != 4) begin failures++; $display("FAIL bp_timeout got %0d beats exp 4", xfer_cnt); end
    checks++; if (exp_q.size() != 0 || pkt_count !== 32'd1) begin failures++; $display("FAIL bp_done got left=%0d pkts=%0d exp 0/1", exp_q.size(), pkt_count); end
  endtask

  task automatic test_orphans();
    beat_t b;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      b.data = {$urandom, $urandom}; b.sop = 1'b0; b.eop = 1'b0; b.empty = 3'd0; b.port = 2'd1;
      src_q[1].push_back(b);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s_in_ready[1] !== 1'b1) begin failures++; $display("FAIL orphan_ready beat %0d got %b exp 1", i, s_in_ready[1]); end
    end
    checks++; if (drop_count !== 16'd3) begin failures++; $display("FAIL orphan_count got %0d exp 3", drop_count); end
    in_valid = 2'b11;
    in_sop   = 2'b00;
    repeat (32771) @(posedge clk);
    #1;
    in_valid = '0;
    checks++; if (drop_count !== 16'hFFFF) begin failures++; $display("FAIL orphan_saturate got %h exp ffff", drop_count); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    beat_t b;
    apply_reset();
    b.data = 64'h0; b.sop = 1'b0; b.eop = 1'b0; b.empty = 3'd0; b.port = 2'd0;
    src_q[0].push_back(b);
    make_pkt(1, 2, 3'd6, 1'b1);
    make_pkt(1, 5, 3'd2, 1'b0);
    exp_q.push_back(src_q[1][2]);
    exp_q.push_back(src_q[1][3]);
    run_until(4, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got %0d beats exp 4", xfer_cnt); end
    checks++;
    if (pkt_count !== 32'd1 || drop_count !== 16'd1 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_pre got pkts=%0d drops=%0d grant=%0d exp 1/1/1", pkt_count, drop_count, grant_id);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle got valid=%b busy=%b exp 0/0", out_valid, busy); end
    checks++; if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin failures++; $display("FAIL rstmid_counters got %0d/%0d exp 0/0", pkt_count, drop_count); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rstmid_grant got %0d exp 0", grant_id); end
    clear_logs();
    make_pkt(1, 2, 3'd1, 1'b1);
    run_until(2, 20, ok);
    checks++; if (!ok || grant_log.size() != 1 || grant_log[0] != 1) begin failures++; $display("FAIL rstmid_fresh got grants=%p exp 1", grant_log); end
    checks++; if (pkt_count !== 32'd1) begin failures++; $display("FAIL rstmid_fresh_count got %0d exp 1", pkt_count); end
  endtask

`ifdef PKT_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    beat_t b;
    apply_reset();
    make_pkt(0, 7, 3'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b = src_q[0][i];
      if (i == 3) begin
        b.eop   = 1'b1;
        b.empty = 3'd0;
      end
      exp_q.push_back(b);
    end
    make_pkt(1, 2, 3'd3, 1'b1);
    run_until(6, 60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wd_timeout got %0d beats exp 6", xfer_cnt); end
    checks++; if (wd_err !== 1'b1) begin failures++; $display("FAIL wd_err got %b exp 1", wd_err); end
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      failures++;
      $display("FAIL wd_order got %p exp 0,1", grant_log);
    end
    checks++; if (pkt_count !== 32'd2 || src_q[0].size() != 0) begin failures++; $display("FAIL wd_count got pkts=%0d left=%0d exp 2/0", pkt_count, src_q[0].size()); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_sop    = '0;
    in_eop    = '0;
    in_empty  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_orphans();
    test_reset_mid_packet();
`ifdef PKT_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
